des_key_scheduler: RTL
======================

// Module: des_key_scheduler
// PURPOSE
// Sequences the DES key schedule for one DES pass of the Triple-DES engine. Latches a 64-bit key,
// applies PC-1 (key_permutation1), then hands 16 48-bit round subkeys to the round datapath over a
// valid/ready handshake. Subkeys are issued K1..K16 for encrypt and K16..K1 for decrypt.
// Bit order, all vectors: index i = FIPS-46 bit i+1, so FIPS bit 1 sits at [0].
// PARAMETERS
// NUM_ROUNDS  16  rounds per DES pass; fixed, sizes round_idx and the shift table
// PORTS
// clk           in   1   system clock, rising edge
// rst           in   1   synchronous active-high reset
// start         in   1   pulse: begin a schedule; sampled only in IDLE
// decrypt       in   1   0 = encrypt order K1..K16, 1 = decrypt order K16..K1; sampled with start
// key_in        in   64  DES key incl. parity bits; sampled with start
// subkey_ready  in   1   round datapath accepts current subkey
// subkey        out  48  current round subkey = PC-2(C,D)
// subkey_valid  out  1   subkey and round_idx are valid
// round_idx     out  4   round number being served, 0..15 (round 1 = 0)
// busy          out  1   schedule in progress
// done          out  1   one-cycle pulse after round 16 subkey accepted
// BEHAVIOUR
// - Clocking: one clock, synchronous active-high reset.
// - Reset values: subkey_valid=0, busy=0, done=0, round_idx=0, C=D=0; subkey = PC-2(0)=0; FSM=IDLE.
// - State: C = PC1[27:0], D = PC1[55:28] (28b each); rnd counter 4b; dir flag; FSM {IDLE, SERVE}.
// - DES left-rotate by n on [27:0]: X' = {X[n-1:0], X[27:n]} (bit [0] moves to [27]).
//   DES right-rotate by n: X' = {X[27-n:0], X[27:28-n]}.
// - Shift table SHIFT[r], r=0..15: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
// - IDLE & start: enc -> C,D = rotl(PC1, SHIFT[0]); dec -> C,D = PC1 unrotated (C16=C0).
//   Latch dir; rnd=0; go SERVE. subkey_valid and busy assert the cycle after start.
// - SERVE: subkey_valid=1 and busy=1. subkey, round_idx stay stable while subkey_valid & !subkey_ready.
// - On subkey_valid & subkey_ready with rnd<15: rnd+=1.
//   enc: C,D = rotl(C,D, SHIFT[rnd+1]). dec: C,D = rotr(C,D, SHIFT[15-rnd]).
// - On subkey_valid & subkey_ready with rnd==15: go IDLE. Next cycle: done=1, subkey_valid=0, busy=0.
//   round_idx returns to 0. C,D hold their last values (not cleared).
// - Latency: start to first subkey = 1 cycle. With ready tied high, 16 subkeys on consecutive cycles.
//   done pulses 17 cycles after start.
// - round_idx = rnd in both directions (position in issue order, not the DES key number).
// - start while busy: ignored; key_in and decrypt are not re-sampled.
// - start in the same cycle as done: accepted, i.e. back-to-back schedules with no bubble beyond done.
// - rst asserted mid-schedule: next cycle returns to reset values. No done pulse; a partial handshake is dropped.
// - subkey_ready while !subkey_valid: ignored.
// - Parity bits key_in[7,15,...,63] have no effect on any output.
// STRUCTURE
// - des_pkg: NUM_ROUNDS, KEY_W=64, CD_W=28, SUBKEY_W=48, SHIFT[0:15] constant array,
//   state enum {IDLE, SERVE}, rotl28/rotr28 functions.
// - Instances: key_permutation1 (PC-1, combinational, on key_in) and a new combinational
//   sub-module key_permutation2 (PC-2, {D,C} 56b -> 48b) driving subkey from the C/D registers.
// - All sequencing lives in this module; no other sub-modules.
// TESTING
// Bench converts FIPS hex to vectors by bit-reversing: FIPS bit 1 (hex MSB) -> index 0.
// 1. Encrypt: key 133457799BBCDFF1, ready=1 -> K1=1B02EFFC7072 at round_idx 0, K2=79AED9DBC9E5,
//    K16=CB3D8B0E17F5 at round_idx 15; done pulses exactly once, 17 cycles after start.
// 2. Decrypt, same key -> round_idx 0 yields CB3D8B0E17F5, round_idx 15 yields 1B02EFFC7072;
//    full sequence is the exact reverse of scenario 1.
// 3. Backpressure: ready low 5 cycles at round_idx 3 -> subkey/round_idx stable all 5 cycles;
//    16 subkeys total, no skip or duplicate.
// 4. start pulsed mid-schedule with a different key -> ignored. start in the done cycle ->
//    new schedule begins, first subkey the following cycle.
// 5. rst high at round_idx 7 -> next cycle valid=busy=done=0, subkey=0; a subsequent start runs a clean schedule.
// 6. Flip every parity bit of the key from scenario 1 -> identical 16-subkey sequence.

Source files
------------

// File: rtl/des_pkg.sv
// Shared constants, permutation tables and rotate helpers for the DES key schedule.
// Vector bit i corresponds to FIPS-46 bit i+1; the tables below are in FIPS numbering.
package des_pkg;

    localparam int NUM_ROUNDS = 16;
    localparam int KEY_W      = 64;
    localparam int CD_W       = 28;
    localparam int PC1_W      = 2 * CD_W;
    localparam int SUBKEY_W   = 48;
    localparam int RND_W      = $clog2(NUM_ROUNDS);

    localparam logic [1:0] SHIFT [0:NUM_ROUNDS-1] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t SERVE = 1'b1;

    // PC-1: output position j takes FIPS key bit PC1_TABLE[j]
    localparam int PC1_TABLE [0:PC1_W-1] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: output position j takes FIPS C||D bit PC2_TABLE[j]
    localparam int PC2_TABLE [0:SUBKEY_W-1] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // With FIPS bit 1 at [0], a DES left rotate moves bit [0] up to [27].
    function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x, input logic [1:0] n);
        logic [CD_W-1:0] r;
        case (n)
            2'd2:    r = {x[1:0], x[CD_W-1:2]};
            default: r = {x[0], x[CD_W-1:1]};
        endcase
        return r;
    endfunction

    function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input logic [1:0] n);
        logic [CD_W-1:0] r;
        case (n)
            2'd2:    r = {x[CD_W-3:0], x[CD_W-1:CD_W-2]};
            default: r = {x[CD_W-2:0], x[CD_W-1]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_permutation1.sv
// PC-1: selects the 56 key bits (C in [27:0], D in [55:28]) from the 64-bit key.
module key_permutation1
    import des_pkg::*;
(
    input  logic [KEY_W-1:0] key_in,
    output logic [PC1_W-1:0] pc1_out
);

    logic [7:0] parity_bits;
    logic       parity_unused;

    genvar gi;
    generate
        for (gi = 0; gi < PC1_W; gi++) begin : g_pc1
            assign pc1_out[gi] = key_in[PC1_TABLE[gi] - 1];
        end
        // Parity bits never reach the schedule; collected only to mark them as intentionally dropped.
        for (gi = 0; gi < 8; gi++) begin : g_parity
            assign parity_bits[gi] = key_in[8 * gi + 7];
        end
    endgenerate

    assign parity_unused = ^parity_bits;

endmodule

// File: rtl/key_permutation2.sv
// PC-2: compresses the 56-bit {D,C} register pair into a 48-bit round subkey.
module key_permutation2
    import des_pkg::*;
(
    input  logic [PC1_W-1:0]    cd,
    output logic [SUBKEY_W-1:0] subkey
);

    logic dropped_unused;

    genvar gi;
    generate
        for (gi = 0; gi < SUBKEY_W; gi++) begin : g_pc2
            assign subkey[gi] = cd[PC2_TABLE[gi] - 1];
        end
    endgenerate

    // FIPS bits 9,18,22,25,35,38,43,54 are discarded by PC-2.
    assign dropped_unused = ^{cd[8], cd[17], cd[21], cd[24], cd[34], cd[37], cd[42], cd[53]};

endmodule

// File: rtl/des_key_scheduler.sv
// DES key schedule sequencer: latches a key, then issues 16 round subkeys over valid/ready,
// K1..K16 for encrypt or K16..K1 for decrypt.
module des_key_scheduler
    import des_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                decrypt,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                subkey_ready,
    output logic [SUBKEY_W-1:0] subkey,
    output logic                subkey_valid,
    output logic [RND_W-1:0]    round_idx,
    output logic                busy,
    output logic                done
);

    logic [PC1_W-1:0] pc1;
    logic [CD_W-1:0]  c_reg, c_next;
    logic [CD_W-1:0]  d_reg, d_next;
    logic [RND_W-1:0] rnd_reg, rnd_next;
    logic             dir_reg, dir_next;
    logic             done_reg, done_next;
    state_t           state_reg, state_next;

    logic [RND_W-1:0] rnd_inc;
    logic [RND_W-1:0] rnd_rev;

    key_permutation1 u_pc1 (
        .key_in  (key_in),
        .pc1_out (pc1)
    );

    key_permutation2 u_pc2 (
        .cd     ({d_reg, c_reg}),
        .subkey (subkey)
    );

    assign rnd_inc = rnd_reg + 1'b1;
    assign rnd_rev = RND_W'(NUM_ROUNDS - 1) - rnd_reg;

    always_comb begin
        c_next     = c_reg;
        d_next     = d_reg;
        rnd_next   = rnd_reg;
        dir_next   = dir_reg;
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    dir_next   = decrypt;
                    rnd_next   = '0;
                    state_next = SERVE;
                    // Decrypt starts from C16/D16, which equals C0/D0 after a full 28-bit rotation.
                    if (decrypt) begin
                        c_next = pc1[CD_W-1:0];
                        d_next = pc1[PC1_W-1:CD_W];
                    end else begin
                        c_next = rotl28(pc1[CD_W-1:0], SHIFT[0]);
                        d_next = rotl28(pc1[PC1_W-1:CD_W], SHIFT[0]);
                    end
                end
            end
            SERVE: begin
                if (subkey_ready) begin
                    if (rnd_reg == RND_W'(NUM_ROUNDS - 1)) begin
                        state_next = IDLE;
                        rnd_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        rnd_next = rnd_inc;
                        if (dir_reg) begin
                            c_next = rotr28(c_reg, SHIFT[rnd_rev]);
                            d_next = rotr28(d_reg, SHIFT[rnd_rev]);
                        end else begin
                            c_next = rotl28(c_reg, SHIFT[rnd_inc]);
                            d_next = rotl28(d_reg, SHIFT[rnd_inc]);
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
                rnd_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_reg     <= '0;
            d_reg     <= '0;
            rnd_reg   <= '0;
            dir_reg   <= 1'b0;
            done_reg  <= 1'b0;
            state_reg <= IDLE;
        end else begin
            c_reg     <= c_next;
            d_reg     <= d_next;
            rnd_reg   <= rnd_next;
            dir_reg   <= dir_next;
            done_reg  <= done_next;
            state_reg <= state_next;
        end
    end

    assign subkey_valid = (state_reg == SERVE);
    assign busy         = (state_reg == SERVE);
    assign round_idx    = rnd_reg;
    assign done         = done_reg;

endmodule
